line_buffer_taps: RTL
=====================

Name: line_buffer_taps

Overview:
- Parametrised successor to the single-tap shift RAM: a cascade of N_TAPS line delays. Each tap delays its input by a run-time line length, measured in accepted samples.
- Feeds 3x3/5x5 window generators in the image pipeline; tap 0 is the previous line, tap k is the line k+1 rows above.
- Adds capabilities the single-tap block lacks: async reset, registered outputs, safe line-length update at line boundaries, per-tap fill status and a line-end strobe.

Parameters:
- MAX_LEN, 1024, maximum line length; sizes each tap RAM; pointer width = $clog2(MAX_LEN).
- N_TAPS, 2, number of cascaded line delays (1..8).
- INPUT_WIDTH, 8, sample width in bits.

Ports:
- clock  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; release is synchronous to clock.
- clken  input  1  sample accept strobe; nothing advances while low.
- delay_len  input  16  requested line length in samples.
- shiftin  input  INPUT_WIDTH  current-line sample.
- shiftout  output  N_TAPS*INPUT_WIDTH  tap k occupies bits [k*INPUT_WIDTH +: INPUT_WIDTH].
- tap_valid  output  N_TAPS  bit k high once tap k holds a complete line.
- line_end  output  1  one-cycle pulse on the edge that accepts the last sample of a line.

Behaviour:
- Reset (async assert): pointer=0, active length L=clamp(delay_len) sampled at release, fill count=0, shiftout=0, tap_valid=0, line_end=0. RAM contents are not cleared; stale data is masked only via tap_valid.
- Clamp rule: delay_len of 0 gives L=1; delay_len > MAX_LEN gives L=MAX_LEN.
- On each edge with clken=1, for every tap k at address ptr:
  - read old RAM_k[ptr];
  - write RAM_k[ptr] <= (k==0 ? shiftin : old RAM_{k-1}[ptr]);
  - register old RAM_k[ptr] into shiftout[k] (read-before-write).
- Latency: shiftout[k] after accepted sample n equals the sample accepted at n-(k+1)*L.
- clken=0: pointer, RAMs, shiftout, fill count hold; line_end=0.
- Pointer: increments on clken; when ptr==L-1 and clken=1, ptr<=0 and line_end=1 for that cycle.
- Length update: delay_len is re-sampled only on the wrap edge. A new L takes effect from the next line.
- On a length change, the fill count resets to 0 and all tap_valid bits clear on that same wrap edge.
- Fill state machine, FILL -> RUN:
  - fill count increments on each wrap, saturating at N_TAPS;
  - tap_valid[k] = (fill count >= k+1);
  - RUN is reached when fill count == N_TAPS, and is left only on reset or a length change.
- L=1: ptr stays 0, line_end pulses on every clken, and each tap is a one-sample delay.
- Reset mid-line: all state returns to its reset values immediately; the first post-reset line refills from ptr=0.

Optional Feature:
- Macro: LINEBUF_FRAME_SYNC_EN.
- Defined: adds input port frame_start (1 bit).
  - When frame_start=1 and clken=1, the current sample is written at address 0 and ptr<=1.
  - The fill count clears, tap_valid<=0, delay_len is re-sampled immediately, and line_end=0 for that cycle.
  - frame_start takes priority over wrap.
- Undefined: no frame_start port; lines are aligned only by reset and pointer wrap.

Test Plan:
- Reset with N_TAPS=2, delay_len=4, then samples 1..12 with clken=1 every cycle -> shiftout tap0 shows 1 on the edge accepting sample 5 and tap1 shows 1 on the edge accepting sample 9; tap_valid=01 after the 4th sample, 11 after the 8th; line_end pulses on samples 4, 8 and 12.
- Same stream with clken toggled 1,0,1,0 -> outputs identical per accepted sample; nothing changes on clken=0 cycles.
- Change delay_len 4->6 mid-line (before the 3rd sample) -> old L=4 finishes the line; then tap_valid=00, and 6-sample lines follow with line_end every 6 accepted samples.
- delay_len=0 -> L=1, tap0 equals the previous sample. delay_len=2000 with MAX_LEN=1024 -> line_end every 1024 samples.
- Assert rst_n low mid-line (after 2 samples) -> shiftout, tap_valid and line_end go to 0 without waiting for a clock edge; after release, refill takes a full L samples per tap.
- With LINEBUF_FRAME_SYNC_EN defined, frame_start at sample 3 of a 4-sample line -> ptr=1 next, tap_valid=00, and the next line_end falls 3 samples later.

Source files
------------

// File: rtl/line_buffer_taps.sv
// Cascade of N_TAPS line delays with run-time line length, per-tap fill status and line-end strobe.
// Define LINEBUF_FRAME_SYNC_EN to add a frame_start input that realigns the line to address 0.
module line_buffer_taps #(
  parameter int MAX_LEN     = 1024,
  parameter int N_TAPS      = 2,
  parameter int INPUT_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          clken,
`ifdef LINEBUF_FRAME_SYNC_EN
  input  logic                          frame_start,
`endif
  input  logic [15:0]                   delay_len,
  input  logic [INPUT_WIDTH-1:0]        shiftin,
  output logic [N_TAPS*INPUT_WIDTH-1:0] shiftout,
  output logic [N_TAPS-1:0]             tap_valid,
  output logic                          line_end
);

  localparam int PTR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int FILL_W = $clog2(N_TAPS + 1);

  typedef enum logic {ST_FILL, ST_RUN} state_t;

  state_t                   state, state_next;
  logic [PTR_W-1:0]         ptr, ptr_next, addr;
  logic [LEN_W-1:0]         len_reg, len_next, req_len, cur_len;
  logic                     len_loaded;
  logic [FILL_W-1:0]        fill, fill_next;
  logic [N_TAPS-1:0]        tap_valid_next;
  logic                     line_end_next;
  logic                     frame_sync, at_last, wrap, restart, advance;
  logic [INPUT_WIDTH-1:0]   rd_data [N_TAPS];

  function automatic logic [LEN_W-1:0] clamp_len(input logic [15:0] req);
    if (req == 16'd0) return LEN_W'(1);
    if (int'(req) > MAX_LEN) return LEN_W'(MAX_LEN);
    return LEN_W'(req);
  endfunction

`ifdef LINEBUF_FRAME_SYNC_EN
  assign frame_sync = clken & frame_start;
`else
  assign frame_sync = 1'b0;
`endif

  // Until the first edge after reset release, the requested length stands in for the register.
  always_comb begin
    req_len = clamp_len(delay_len);
    cur_len = len_loaded ? len_reg : req_len;
    at_last = (LEN_W'(ptr) == cur_len - LEN_W'(1));
    wrap    = clken & at_last & ~frame_sync;
    restart = frame_sync | (wrap & (req_len != cur_len));
    advance = wrap & ~restart;
    addr    = frame_sync ? '0 : ptr;
  end

  always_comb begin
    ptr_next      = ptr;
    len_next      = cur_len;
    line_end_next = 1'b0;
    if (frame_sync) begin
      ptr_next = (req_len == LEN_W'(1)) ? '0 : PTR_W'(1);
      len_next = req_len;
    end else if (wrap) begin
      ptr_next      = '0;
      len_next      = req_len;
      line_end_next = 1'b1;
    end else if (clken) begin
      ptr_next = ptr + PTR_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    fill_next  = fill;
    unique case (state)
      ST_FILL: begin
        if (restart) begin
          fill_next = '0;
        end else if (advance) begin
          fill_next = fill + FILL_W'(1);
          if (fill_next == FILL_W'(N_TAPS)) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (restart) begin
          fill_next  = '0;
          state_next = ST_FILL;
        end
      end
      default: begin
        fill_next  = '0;
        state_next = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      ptr        <= '0;
      len_reg    <= LEN_W'(1);
      len_loaded <= 1'b0;
      fill       <= '0;
      tap_valid  <= '0;
      line_end   <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      len_reg    <= len_next;
      len_loaded <= 1'b1;
      fill       <= fill_next;
      tap_valid  <= tap_valid_next;
      line_end   <= line_end_next;
    end
  end

  // Each tap RAM is read before write at the shared address; tap k is fed from tap k-1's old word.
  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
    logic [INPUT_WIDTH-1:0] ram [MAX_LEN];
    logic [INPUT_WIDTH-1:0] wr_data;
    logic [INPUT_WIDTH-1:0] tap_q;

    if (gi == 0) begin : g_head
      assign wr_data = shiftin;
    end else begin : g_link
      assign wr_data = rd_data[gi-1];
    end

    assign rd_data[gi]     = ram[addr];
    assign tap_valid_next[gi] = (fill_next >= FILL_W'(gi + 1));
    assign shiftout[gi*INPUT_WIDTH +: INPUT_WIDTH] = tap_q;

    always_ff @(posedge clock) begin
      if (clken) ram[addr] <= wr_data;
    end

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        tap_q <= '0;
      end else if (clken) begin
        tap_q <= rd_data[gi];
      end
    end
  end

endmodule
